// File: rtl/mealy_stim_driver.sv
// Paced stimulus driver for a 4-state Mealy target. It buffers symbols in a FIFO and steps the target at most once every DIV cycles.
// A shadow model of the target checks the target's state and output, and counts each cycle that has a mismatch.
module mealy_stim_driver #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DIV   = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sym_valid,
    input  logic [1:0]       sym_data,
    output logic             sym_ready,
    input  logic             out_mealy,
    input  logic [1:0]       state_mealy,
    output logic             en_mealy,
    output logic [1:0]       in_mealy,
    output logic [1:0]       shadow_state,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             clr_err
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam int unsigned PACE_W = $clog2(DIV + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } ctrl_t;

    ctrl_t             state;
    ctrl_t             state_nxt;
    logic [1:0]        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W-1:0]  occ_nxt;
    logic [PACE_W-1:0] pace;
    logic              empty;
    logic              push;
    logic              pop;
    logic              mismatch;

    // Reference transition table; symbol 0 holds the state.
    function automatic logic [1:0] model_next(input logic [1:0] s, input logic [1:0] sym);
        logic [1:0] n;
        n = s;
        case ({s, sym})
            4'b00_01: n = 2'd3;
            4'b00_10: n = 2'd1;
            4'b00_11: n = 2'd2;
            4'b01_01: n = 2'd0;
            4'b01_10: n = 2'd3;
            4'b01_11: n = 2'd2;
            4'b10_01: n = 2'd1;
            4'b10_10: n = 2'd0;
            4'b10_11: n = 2'd3;
            4'b11_01: n = 2'd1;
            4'b11_10: n = 2'd0;
            4'b11_11: n = 2'd2;
            default:  n = s;
        endcase
        return n;
    endfunction

    function automatic logic model_out(input logic [1:0] s, input logic [1:0] sym);
        return ({s, sym} == 4'b00_01) || ({s, sym} == 4'b00_10) ||
               ({s, sym} == 4'b01_01) || ({s, sym} == 4'b10_00);
    endfunction

    assign empty = (occ == '0);

    // Handshakes, FIFO occupancy and mismatch detection.
    always_comb begin
        push     = sym_valid && sym_ready;
        pop      = (state_nxt == ISSUE);
        occ_nxt  = occ + OCC_W'(push) - OCC_W'(pop);
        mismatch = (state_mealy != shadow_state) ||
                   (en_mealy && (out_mealy != model_out(shadow_state, in_mealy)));
    end

    // Controller next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty && pace == '0) state_nxt = ISSUE;
            ISSUE: begin
                if (DIV > 1)     state_nxt = WAIT;
                else if (!empty) state_nxt = ISSUE;
                else             state_nxt = IDLE;
            end
            WAIT:    if (pace <= PACE_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sym_data;
    end

    // The pacing count starts at DIV-1 on each issue and counts down every cycle until it reaches 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            pace      <= '0;
            en_mealy  <= 1'b0;
            in_mealy  <= 2'd0;
            sym_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            occ       <= occ_nxt;
            sym_ready <= (occ_nxt != OCC_W'(DEPTH));
            busy      <= (occ_nxt != '0) || (state_nxt != IDLE);
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                in_mealy <= mem[rd_ptr];
                en_mealy <= 1'b1;
                pace     <= PACE_W'(DIV - 1);
            end else begin
                en_mealy <= 1'b0;
                if (pace != '0) pace <= pace - PACE_W'(1);
            end
        end
    end

    // The shadow state advances at the end of each step. Mismatch cycles are counted until the count saturates, and clr_err takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_state <= 2'd2;
            err          <= 1'b0;
            err_cnt      <= '0;
        end else begin
            if (en_mealy) shadow_state <= model_next(shadow_state, in_mealy);
            if (clr_err) begin
                err     <= 1'b0;
                err_cnt <= '0;
            end else if (mismatch) begin
                err <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mealy_stim_driver.sv
// Randomized, scoreboard-checked bench for mealy_stim_driver, with a behavioural target FSM and a table-driven model.
// A second instance with slow pacing is used for the FIFO-full and ordering checks.
module tb_mealy_stim_driver;

    localparam int unsigned DIV   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             sym_valid = 1'b0;
    logic [1:0]       sym_data = 2'd0;
    logic             sym_ready;
    logic             out_mealy;
    logic [1:0]       state_mealy;
    logic             en_mealy;
    logic [1:0]       in_mealy;
    logic [1:0]       shadow_state;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
    logic             clr_err = 1'b0;

    logic       sym_valid2 = 1'b0;
    logic [1:0] sym_data2 = 2'd0;
    logic       sym_ready2, en2, busy2, err2;
    logic [1:0] in2, shadow2, state2;
    logic [7:0] err_cnt2;

    mealy_stim_driver #(.DEPTH(DEPTH), .DIV(DIV), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_data(sym_data),
        .sym_ready(sym_ready), .out_mealy(out_mealy), .state_mealy(state_mealy),
        .en_mealy(en_mealy), .in_mealy(in_mealy), .shadow_state(shadow_state),
        .busy(busy), .err(err), .err_cnt(err_cnt), .clr_err(clr_err)
    );

    mealy_stim_driver #(.DEPTH(DEPTH), .DIV(200), .CNT_W(8)) dut_slow (
        .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid2), .sym_data(sym_data2),
        .sym_ready(sym_ready2), .out_mealy(1'b0), .state_mealy(state2),
        .en_mealy(en2), .in_mealy(in2), .shadow_state(shadow2),
        .busy(busy2), .err(err2), .err_cnt(err_cnt2), .clr_err(1'b0)
    );
    assign state2 = shadow2;

    // Transition and output tables, indexed by state*4 + symbol.
    int nxt_tab [16] = '{0, 3, 1, 2,  1, 0, 3, 2,  2, 1, 0, 3,  3, 1, 0, 2};
    int out_tab [16] = '{0, 1, 1, 0,  0, 1, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0};

    // Behavioural target FSM, with optional fault injection.
    logic [1:0] tgt;
    logic       fault_out = 1'b0;
    logic       fault_state = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        tgt <= 2'd2;
        else if (en_mealy) tgt <= 2'(nxt_tab[int'(tgt) * 4 + int'(in_mealy)]);
    end
    always_comb begin
        out_mealy   = (out_tab[int'(tgt) * 4 + int'(in_mealy)] != 0) ^ fault_out;
        state_mealy = tgt ^ {1'b0, fault_state};
    end

    typedef struct {
        logic [1:0] sym;
        logic [1:0] pre;
        int         push_edge;
    } exp_t;

    exp_t       sbq[$];
    logic [1:0] q2[$];
    logic [1:0] mstate = 2'd2;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_pulse = -1000;
    int         pulses[$];
    exp_t       e;
    logic [1:0] w2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor for the main instance: pop the expected entry and compare it on every step.
    always @(negedge clk) begin
        if (rst_n && en_mealy) begin
            if (sbq.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("in_mealy", int'(in_mealy), int'(e.sym));
                chk("shadow_pre_step", int'(shadow_state), int'(e.pre));
                chk("issue_not_early", int'(cyc >= e.push_edge + 1), 1);
            end
            chk("pace_gap_ge_div", int'(cyc - last_pulse >= int'(DIV)), 1);
            last_pulse = cyc;
            pulses.push_back(cyc);
        end
    end

    // Monitor for the slow instance: checks FIFO order.
    always @(negedge clk) begin
        if (rst_n && en2) begin
            if (q2.size() == 0) begin
                chk("unexpected_pulse_slow", 1, 0);
            end else begin
                w2 = q2.pop_front();
                chk("fifo_order", int'(in2), int'(w2));
            end
        end
    end

    task automatic push(input logic [1:0] s);
        int t = 0;
        sym_valid = 1'b1;
        sym_data  = s;
        while (!sym_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!sym_ready) begin
            chk("push_timeout", 0, 1);
        end else begin
            sbq.push_back('{sym: s, pre: mstate, push_edge: cyc + 1});
            mstate = 2'(nxt_tab[int'(mstate) * 4 + int'(s)]);
        end
        @(negedge clk);
        sym_valid = 1'b0;
    endtask

    task automatic push_slow(input logic [1:0] s);
        sym_valid2 = 1'b1;
        sym_data2  = s;
        chk("slow_ready_on_push", int'(sym_ready2), 1);
        if (sym_ready2) q2.push_back(s);
        @(negedge clk);
        sym_valid2 = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int t = 0;
        while ((busy || sbq.size() != 0) && t < bound) begin
            @(negedge clk);
            t++;
        end
        if (busy || sbq.size() != 0) chk("drain_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        sym_valid   = 1'b0;
        sym_valid2  = 1'b0;
        clr_err     = 1'b0;
        fault_out   = 1'b0;
        fault_state = 1'b0;
        sbq.delete();
        q2.delete();
        mstate      = 2'd2;
        last_pulse  = -1000;
        repeat (2) @(negedge clk);
        chk("rst_shadow", int'(shadow_state), 2);
        chk("rst_en", int'(en_mealy), 0);
        chk("rst_in", int'(in_mealy), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(sym_ready), 1);
        rst_n = 1'b1;
    endtask

    initial begin
        int n0;
        @(negedge clk);
        do_reset();

        // Directed sequence 2,2,1,3 against a correct target.
        pulses.delete();
        push(2'd2); push(2'd2); push(2'd1); push(2'd3);
        wait_drain(100);
        chk("seq_pulse_count", pulses.size(), 4);
        if (pulses.size() == 4) begin
            for (int i = 1; i < 4; i++) chk("seq_pulse_spacing", pulses[i] - pulses[i-1], 4);
        end
        chk("seq_final_shadow", int'(shadow_state), 2);
        chk("seq_err", int'(err), 0);

        // Output fault: from S0, apply symbol 1 while the target's output is forced to 0.
        push(2'd2);
        wait_drain(50);
        chk("to_s0_shadow", int'(shadow_state), 0);
        fault_out = 1'b1;
        push(2'd1);
        wait_drain(50);
        fault_out = 1'b0;
        chk("outfault_err", int'(err), 1);
        chk("outfault_err_cnt", int'(err_cnt), 1);
        chk("outfault_shadow", int'(shadow_state), 3);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("clr_err_flag", int'(err), 0);
        chk("clr_err_cnt", int'(err_cnt), 0);

        // Symbol 0 from S2: the state is held and the predicted output is 1.
        push(2'd3); push(2'd0);
        wait_drain(50);
        chk("sym0_shadow_hold", int'(shadow_state), 2);
        chk("sym0_no_err", int'(err), 0);

        // Saturation with a 2-bit count; clr_err wins over a mismatch in the same cycle.
        fault_state = 1'b1;
        repeat (2) @(negedge clk);
        chk("sat_cnt_2", int'(err_cnt), 2);
        chk("sat_err_set", int'(err), 1);
        repeat (4) @(negedge clk);
        chk("sat_cnt_3", int'(err_cnt), 3);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err     = 1'b0;
        fault_state = 1'b0;
        chk("clr_prio_cnt", int'(err_cnt), 0);
        chk("clr_prio_err", int'(err), 0);
        @(negedge clk);
        chk("post_clr_err", int'(err), 0);

        // FIFO full on the slow instance: the fifth push is refused and the order is preserved.
        push_slow(2'd1);
        repeat (2) @(negedge clk);
        push_slow(2'd2); push_slow(2'd3); push_slow(2'd0); push_slow(2'd1);
        chk("full_ready_low", int'(sym_ready2), 0);
        sym_valid2 = 1'b1;
        sym_data2  = 2'd3;
        repeat (3) @(negedge clk);
        sym_valid2 = 1'b0;
        for (int t = 0; t < 1500 && q2.size() != 0; t++) @(negedge clk);
        chk("full_drain_done", q2.size(), 0);
        repeat (250) @(negedge clk);
        chk("full_idle_after", int'(busy2), 0);

        // Reset during WAIT with three symbols queued.
        push(2'd1); push(2'd2); push(2'd3); push(2'd0);
        chk("wait_busy_before_rst", int'(busy), 1);
        chk("wait_queued", sbq.size(), 3);
        do_reset();
        n0 = pulses.size();
        repeat (30) @(negedge clk);
        chk("no_pulse_after_rst", pulses.size(), n0);
        push(2'd2);
        wait_drain(50);
        chk("post_rst_shadow", int'(shadow_state), 0);

        // Randomized symbols with random gaps between pushes.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            push(2'($urandom_range(0, 3)));
        end
        wait_drain(400);
        chk("rand_no_err", int'(err), 0);
        chk("rand_shadow", int'(shadow_state), int'(mstate));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
